// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU of the pipelined RISC-V core.
// AND/OR/ADD/SUB are combinational. MUL uses an iterative shift-add
// multiplier that stalls the pipeline for WIDTH+1 cycles. The product is then
// presented for one cycle with a mul_done_o pulse.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset
//   valid_i     EX stage holds a valid instruction
//   ALUCtrl_i   operation code (AND 0000, OR 0001, ADD 0010, SUB 0110, MUL 1000)
//   data1_i     operand A
//   data2_i     operand B
//   data_o      EX result
//   zero_o      data_o == 0
//   stall_o     hold IF/ID/EX while a multiply is pending
//   mul_done_o  one-cycle pulse when the MUL result is presented
module ex_alu_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             stall_o,
    output logic             mul_done_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpMul = 4'b1000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CntW-1:0]   count_q, count_d;

    logic              mul_start;
    logic              last_step;
    logic [WIDTH-1:0]  alu_res;

    assign mul_start = (state_q == StIdle) && valid_i && (ALUCtrl_i == OpMul);
    assign last_step = (count_q == CntW'(WIDTH - 1));

    // Combinational result path used while idle. MUL and unknown codes give 0.
    always_comb begin
        alu_res = '0;
        unique case (ALUCtrl_i)
            OpAnd:   alu_res = data1_i & data2_i;
            OpOr:    alu_res = data1_i | data2_i;
            OpAdd:   alu_res = data1_i + data2_i;
            OpSub:   alu_res = data1_i - data2_i;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (mul_start) begin
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CntW'(1);
                if (last_step) begin
                    state_d = StDone;
                end
            end
            // Inputs are ignored here so a MUL still held upstream is not restarted.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    assign data_o     = (state_q == StIdle) ? alu_res : acc_q;
    assign zero_o     = (data_o == '0);
    // Gated by reset so a MUL held on the inputs cannot raise stall while reset is asserted.
    assign stall_o    = rst_i && (mul_start || (state_q == StBusy));
    assign mul_done_o = (state_q == StDone);

endmodule

// File: tb/tb_ex_alu_unit.sv
module tb_ex_alu_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [3:0]   ctrl;
    logic [W-1:0] a, b;
    logic [W-1:0] data;
    logic         zero, stall, done;

    ex_alu_unit #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .valid_i    (valid),
        .ALUCtrl_i  (ctrl),
        .data1_i    (a),
        .data2_i    (b),
        .data_o     (data),
        .zero_o     (zero),
        .stall_o    (stall),
        .mul_done_o (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         done;
        int           stalls;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic pres  = 1'b0;   // a scoreboarded instruction is on the inputs
    int   stall_cnt = 0;
    int   stray_done = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, req);
        end
    endtask

    // Reference model: plain arithmetic from the opcode table.
    function automatic exp_t model(input logic [3:0] op, input logic v,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] p;
        e.done   = 1'b0;
        e.stalls = 0;
        case (op)
            4'b0000: e.data = x & y;
            4'b0001: e.data = x | y;
            4'b0010: e.data = x + y;
            4'b0110: e.data = x - y;
            4'b1000: begin
                if (v) begin
                    p        = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                    e.data   = p[W-1:0];
                    e.done   = 1'b1;
                    e.stalls = W + 1;
                end else begin
                    e.data = '0;
                end
            end
            default: e.data = '0;
        endcase
        e.zero = (e.data == '0);
        return e;
    endfunction

    // Monitor: counts stall cycles, pops on the first non-stalled cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !pres) begin
            stall_cnt = 0;
            if (done) stray_done++;
        end else if (stall) begin
            stall_cnt++;
        end else begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", data, e.data);
                check("zero", {31'd0, zero}, {31'd0, e.zero});
                check("mul_done", {31'd0, done}, {31'd0, e.done});
                check("stall_cycles", stall_cnt, e.stalls);
            end
            stall_cnt = 0;
        end
    end

    task automatic issue(input logic [3:0] op, input logic v,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        bit seen;
        exp_q.push_back(model(op, v, x, y));
        @(posedge clk);
        #1;
        ctrl = op; valid = v; a = x; b = y; pres = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (!stall) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("stall_timeout", 32'd1, 32'd0);
    endtask

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                              4'b1000, 4'b1000, 4'b0111, 4'b1111};

    initial begin
        rst_n = 1'b0; valid = 1'b1; ctrl = 4'b1000; a = 32'd3; b = 32'd4;
        #12;
        // Reset state with a MUL held on the inputs.
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        ctrl = 4'b0010;
        @(posedge clk); #1 rst_n = 1'b1;

        issue(4'b0010, 1'b1, 32'd5, 32'd7);
        issue(4'b0110, 1'b1, 32'd9, 32'd9);
        issue(4'b0000, 1'b1, 32'h0000F0F0, 32'h00000FF0);
        issue(4'b0001, 1'b1, 32'h0000F0F0, 32'h00000FF0);
        issue(4'b1000, 1'b1, 32'd3, 32'hFFFFFFFE);
        issue(4'b1000, 1'b1, 32'h00010000, 32'h00010000);
        issue(4'b1000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(4'b1000, 1'b1, 32'd6, 32'd7);
        issue(4'b1000, 1'b1, 32'd5, 32'd5);
        issue(4'b1000, 1'b0, 32'd5, 32'd5);
        issue(4'b0111, 1'b1, 32'd5, 32'd5);

        // Abort a multiply with reset part-way through BUSY.
        @(posedge clk); #1;
        pres = 1'b0; stray_done = 0;
        ctrl = 4'b1000; valid = 1'b1; a = 32'd11; b = 32'd13;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        ctrl = 4'b0010; a = 32'd1; b = 32'd1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        check("abort_no_done_pulse", stray_done, 0);
        issue(4'b0010, 1'b1, 32'd1, 32'd1);

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if ($urandom_range(0, 5) == 0) y = x;
            issue(codes[$urandom_range(0, 7)], ($urandom_range(0, 7) != 0), x, y);
        end

        @(posedge clk); #1 pres = 1'b0;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_alu_unit.md
# ex_alu_unit

Execute-stage ALU of the pipelined RISC-V core. It sits directly downstream of the ALU control decoder: it takes the 4-bit ALU control code plus the two operands and produces the EX result and zero flag. AND, OR, ADD and SUB complete combinationally in the same cycle. MUL runs on an iterative shift-add multiplier that stalls the pipeline until the product is ready.

## Interface
- WIDTH, 32, operand/result width in bits
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; asynchronous, active-low
- valid_i  input  1  EX stage holds a valid instruction
- ALUCtrl_i  input  4  operation code from the ALU control decoder:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 1000 MUL
  - any other code → result 0
- data1_i  input  WIDTH  operand A (rs1)
- data2_i  input  WIDTH  operand B (rs2 or immediate)
- data_o  output  WIDTH  EX result
- zero_o  output  1  data_o == 0
- stall_o  output  1  hold IF/ID/EX; EX inputs must stay stable while high
- mul_done_o  output  1  one-cycle pulse when a MUL result is presented

## Operation
- FSM states:
  - IDLE: reset state.
  - BUSY: multiply in progress.
  - DONE: product presented for one cycle.
- IDLE, non-MUL code:
  - data_o is combinational from the inputs.
  - AND/OR are bitwise.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - stall_o = 0.
- IDLE, code MUL with valid_i = 1:
  - stall_o = 1 combinationally in that cycle.
  - At the edge: latch mcand = data1_i, mplier = data2_i; clear acc and count; go to BUSY.
- IDLE, code MUL with valid_i = 0: data_o = 0, stall_o = 0, no start.
- BUSY, each edge:
  - if mplier[0], acc += mcand (mod 2^WIDTH)
  - mcand <<= 1; mplier >>= 1; count++
  - when count == WIDTH-1 at the edge, go to DONE
  - stall_o = 1 throughout; data_o = acc (not valid yet); inputs ignored
- DONE (exactly one cycle):
  - data_o = acc, the low WIDTH bits of the product; identical for signed and unsigned operands.
  - stall_o = 0, mul_done_o = 1.
  - Inputs are ignored, so the held MUL is not restarted.
  - Next state is IDLE unconditionally.
- zero_o always reflects the current data_o.
- Reset (asserted at any time, including mid-BUSY):
  - Immediately go to IDLE; acc, mcand, mplier and count clear to 0.
  - stall_o = 0 and mul_done_o = 0.
  - The aborted multiply produces no result.
- Internal registers: acc, mcand, mplier (WIDTH each), count (log2(WIDTH) bits), state (2 bits).

## Timing
- Reset values:
  - stall_o = 0, mul_done_o = 0
  - data_o follows the IDLE combinational path (0 for MUL or undefined codes)
  - zero_o follows data_o
- Non-MUL latency: 0 cycles (combinational), no stall.
- MUL accepted in cycle T:
  - BUSY occupies cycles T+1 … T+WIDTH.
  - DONE is cycle T+WIDTH+1.
  - stall_o is high for WIDTH+1 cycles (T … T+WIDTH); the result is valid in T+WIDTH+1.
  - Fixed latency, independent of operand values. No early termination.
- Back-to-back MULs:
  - The cycle after DONE is IDLE with the next instruction presented.
  - If it is a MUL, it is accepted there.
  - Minimum MUL-to-MUL spacing: WIDTH+2 cycles.
- The upstream stage must keep ALUCtrl_i, data1_i, data2_i and valid_i stable while stall_o = 1. The block does not depend on this, because operands are latched at acceptance.

## Test plan
- ADD 5 + 7 → data_o = 12, zero_o = 0, stall_o = 0 in the same cycle. SUB 9 − 9 → data_o = 0, zero_o = 1. AND 0xF0F0 & 0x0FF0 → 0x00F0. OR → 0xFFF0.
- MUL 3 × 0xFFFFFFFE (−2) accepted at T → stall_o high for exactly 33 cycles. At T+33: data_o = 0xFFFFFFFA, stall_o = 0, mul_done_o = 1 for one cycle; IDLE at T+34.
- MUL 0x00010000 × 0x00010000 → DONE data_o = 0 and zero_o = 1 (truncation). MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- Assert rst_i low at cycle T+10 of a MUL → stall_o = 0 immediately, asynchronously. After release, ADD 1 + 1 → 2 with no stall. mul_done_o never pulses for the aborted MUL.
- Two consecutive MULs (6 × 7, then 5 × 5) with inputs held during stall → results 42 and 25, each with exactly one mul_done_o pulse. The first MUL is not re-executed in DONE.
- valid_i = 0 with code MUL → no stall, data_o = 0, zero_o = 1. Undefined code 0111 with valid_i = 1 → data_o = 0, zero_o = 1, stall_o = 0.
